// File: rtl/goldschmidt_ctrl_if.sv
// -----------------------------------------------------------------------------
// goldschmidt_ctrl_if
// Handshake and datapath-steering bundle between the Goldschmidt sequencer and
// the host/datapath it controls.
//
//   start      host -> ctrl   request a division (sampled only while idle)
//   busy       ctrl -> host   high whenever the sequencer is not idle
//   done       ctrl -> host   one-cycle pulse, quotient valid in regN
//   load_regN  ctrl -> dp     capture multiplier output into regN
//   load_regD  ctrl -> dp     capture multiplier output into regD
//   load_regK  ctrl -> dp     capture 2 - regD into regK
//   sel_ND_mux ctrl -> dp     multiplier A operand: 00 hold, 01 D side, 10 N side
//   sel_K_mux  ctrl -> dp     multiplier B operand: 0 = IA, 1 = regK
//
// The slave modport is the sequencer; the master modport is the host/datapath.
// -----------------------------------------------------------------------------
interface goldschmidt_ctrl_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       load_regN;
    logic       load_regD;
    logic       load_regK;
    logic [1:0] sel_ND_mux;
    logic       sel_K_mux;

    modport slave (
        input  start,
        output busy,
        output done,
        output load_regN,
        output load_regD,
        output load_regK,
        output sel_ND_mux,
        output sel_K_mux
    );

    modport master (
        output start,
        input  busy,
        input  done,
        input  load_regN,
        input  load_regD,
        input  load_regK,
        input  sel_ND_mux,
        input  sel_K_mux
    );
endinterface

// File: rtl/goldschmidt_ctrl.sv
// -----------------------------------------------------------------------------
// goldschmidt_ctrl
// Sequencing FSM for a Goldschmidt divider datapath (N/D registers, one shared
// multiplier, K = 2 - D). A division runs the initial-approximation step
// (K = IA) followed by ITERS refinement steps (K = regK). Every step is two
// cycles, D*K then N*K, because the multiplier is shared. done pulses for one
// cycle once the last N*K product has been captured.
//
// Parameters
//   ITERS  refinement steps after the IA step, 1 .. 2**CNT_W-1
//   CNT_W  width of the iteration counter
//
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    goldschmidt_ctrl_if.slave: start in; busy, done, loads, selects out
//
// All outputs are a Moore decode of the state register, so asserting reset
// clears them immediately through the asynchronous state reset.
// -----------------------------------------------------------------------------
module goldschmidt_ctrl #(
    parameter int unsigned ITERS = 3,
    parameter int unsigned CNT_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    goldschmidt_ctrl_if.slave  bus
);

    // Counter must be able to hold ITERS-1 without wrapping.
    generate
        if (ITERS < 1 || ITERS > (2 ** CNT_W) - 1) begin : g_bad_iters
            $error("goldschmidt_ctrl: ITERS=%0d out of range 1..%0d for CNT_W=%0d",
                   ITERS, (2 ** CNT_W) - 1, CNT_W);
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT_D = 3'd1,
        S_INIT_N = 3'd2,
        S_ITER_D = 3'd3,
        S_ITER_N = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_D    = 2'b01;
    localparam logic [1:0] SEL_N    = 2'b10;

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   iter_cnt_q, iter_cnt_d;

    // -------------------------------------------------------------------------
    // State and counter registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            iter_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            iter_cnt_q <= iter_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and Moore output decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        iter_cnt_d     = iter_cnt_q;
        bus.busy       = 1'b1;
        bus.done       = 1'b0;
        bus.load_regN  = 1'b0;
        bus.load_regD  = 1'b0;
        bus.load_regK  = 1'b0;
        bus.sel_ND_mux = SEL_NONE;
        bus.sel_K_mux  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    state_d = S_INIT_D;
                end
            end

            // D <- D * IA
            S_INIT_D: begin
                bus.sel_ND_mux = SEL_D;
                bus.load_regD  = 1'b1;
                state_d        = S_INIT_N;
            end

            // N <- N * IA ; K <- 2 - regD
            S_INIT_N: begin
                bus.sel_ND_mux = SEL_N;
                bus.load_regN  = 1'b1;
                bus.load_regK  = 1'b1;
                iter_cnt_d     = '0;
                state_d        = S_ITER_D;
            end

            // D <- regD * regK
            S_ITER_D: begin
                bus.sel_ND_mux = SEL_D;
                bus.sel_K_mux  = 1'b1;
                bus.load_regD  = 1'b1;
                state_d        = S_ITER_N;
            end

            // N <- regN * regK ; K <- 2 - regD ; count the finished step
            S_ITER_N: begin
                bus.sel_ND_mux = SEL_N;
                bus.sel_K_mux  = 1'b1;
                bus.load_regN  = 1'b1;
                bus.load_regK  = 1'b1;
                iter_cnt_d     = iter_cnt_q + 1'b1;
                if (iter_cnt_q == LAST_ITER) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ITER_D;
                end
            end

            // start is deliberately ignored here; a held start is only
            // accepted after one cycle back in IDLE.
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Structural invariants of the load decode
    // -------------------------------------------------------------------------
    ap_k_with_n: assert property (@(posedge clk) disable iff (!reset)
        bus.load_regK |-> bus.load_regN);

    ap_one_load: assert property (@(posedge clk) disable iff (!reset)
        !(bus.load_regN && bus.load_regD));

endmodule
